// File: rtl/imm_pkg.sv
// Shared constants, types and helpers for the immediate encoder.
// Holds the direct (single-cycle) encodings and the 32-bit rotate used by the rotated-imm search.
package imm_pkg;

    localparam int unsigned VALUE_W = 32;
    localparam int unsigned FIELD_W = 24;
    localparam int unsigned ROT_W   = 4;

    localparam logic [ROT_W-1:0] ROT_LAST = 4'd15;

    localparam logic [1:0] IMM8   = 2'b00;
    localparam logic [1:0] IMM12  = 2'b01;
    localparam logic [1:0] BRANCH = 2'b10;
    localparam logic [1:0] ROT8   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_e;

    typedef struct packed {
        logic               ok;
        logic [FIELD_W-1:0] x;
    } imm_result_t;

    function automatic logic [VALUE_W-1:0] rol32(input logic [VALUE_W-1:0] v,
                                                 input logic [4:0]         amt);
        logic [2*VALUE_W-1:0] t;
        t = {v, v} << amt;
        return t[2*VALUE_W-1:VALUE_W];
    endfunction

    // Encodings for the modes that resolve in a single step; unencodable gives all zeros.
    function automatic imm_result_t encode_direct(input logic [1:0]         mode,
                                                  input logic [VALUE_W-1:0] v);
        imm_result_t res;
        res = '0;
        case (mode)
            IMM8: begin
                if (v[31:8] == 24'd0) begin
                    res.ok = 1'b1;
                    res.x  = {16'd0, v[7:0]};
                end
            end
            IMM12: begin
                if (v[31:12] == 20'd0) begin
                    res.ok = 1'b1;
                    res.x  = {12'd0, v[11:0]};
                end
            end
            BRANCH: begin
                if ((v[1:0] == 2'b00) && ((&v[31:25]) || !(|v[31:25]))) begin
                    res.ok = 1'b1;
                    res.x  = v[25:2];
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_rot_match.sv
// Combinational check of one rotation candidate: rotate left by 2*r and test
// that the result fits in the low byte.
module imm_rot_match
    import imm_pkg::*;
(
    input  logic [VALUE_W-1:0] value,
    input  logic [ROT_W-1:0]   r,
    output logic               match,
    output logic [7:0]         imm8
);

    logic [VALUE_W-1:0] rotated;

    always_comb begin
        rotated = rol32(value, {r, 1'b0});
        match   = (rotated[31:8] == 24'd0);
        imm8    = rotated[7:0];
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: turns a 32-bit constant into the instruction immediate field for the
// selected mode; rotated-imm mode walks one even rotation per clock, smallest first.
module imm_encoder
    import imm_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VALUE_W-1:0] value,
    input  logic [1:0]         ImmSrc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] x,
    output logic               ok
);

    state_e             state_q, state_d;
    logic [ROT_W-1:0]   rot_q, rot_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [FIELD_W-1:0] x_q, x_d;
    logic               ok_q, ok_d;

    logic               rot_match;
    logic [7:0]         rot_imm8;
    imm_result_t        direct;

    imm_rot_match u_rot_match (
        .value (value_q),
        .r     (rot_q),
        .match (rot_match),
        .imm8  (rot_imm8)
    );

    always_comb begin
        direct = encode_direct(ImmSrc, value);
    end

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        x_d     = x_q;
        ok_d    = ok_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = value;
                    rot_d   = '0;
                    if (ImmSrc == ROT8) begin
                        x_d     = '0;
                        ok_d    = 1'b0;
                        state_d = SEARCH;
                    end else begin
                        x_d     = direct.x;
                        ok_d    = direct.ok;
                        state_d = DONE;
                    end
                end
            end
            SEARCH: begin
                if (rot_match) begin
                    x_d     = {12'd0, rot_q, rot_imm8};
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if (rot_q == ROT_LAST) begin
                    // Last candidate failed; counter stops here rather than wrapping.
                    x_d     = '0;
                    ok_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rot_q   <= '0;
            value_q <= '0;
            x_q     <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            x_q     <= x_d;
            ok_q    <= ok_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x         = x_q;
    assign ok        = ok_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors with literal expectations, a behavioural encoder
// model checked every result cycle, and an independent extender for round-trip checks.
module tb_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] x;
    logic        ok;

    int          checks;
    int          errors;
    logic [23:0] exp_x;
    logic        exp_ok;

    imm_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .ImmSrc    (ImmSrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .ok        (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Model: what the encoded field must be, from the extender's rules, with plain arithmetic.
    function automatic void model(input logic [1:0] m, input logic [31:0] v,
                                  output logic [23:0] mx, output logic mok, output int mlat);
        longint unsigned vv;
        longint unsigned rot;
        longint signed   sv;
        logic            found;
        vv    = longint'(v);
        sv    = longint'($signed(v));
        mx    = '0;
        mok   = 1'b0;
        mlat  = 1;
        found = 1'b0;
        case (m)
            2'd0: if (vv < 256) begin mok = 1'b1; mx = 24'(vv); end
            2'd1: if (vv < 4096) begin mok = 1'b1; mx = 24'(vv); end
            2'd2: begin
                if ((sv % 4 == 0) && (sv >= -(64'sd1 << 25)) && (sv < (64'sd1 << 25))) begin
                    mok = 1'b1;
                    mx  = 24'(sv / 4);
                end
            end
            default: begin
                mlat = 17;
                for (int r = 0; r < 16; r++) begin
                    if (!found) begin
                        rot = ((vv * (64'd1 << (2 * r))) % (64'd1 << 32))
                              + (vv / (64'd1 << (32 - 2 * r)));
                        if (rot < 256) begin
                            found = 1'b1;
                            mok   = 1'b1;
                            mx    = 24'(r * 256 + int'(rot));
                            mlat  = r + 2;
                        end
                    end
                end
            end
        endcase
    endfunction

    // Extender: expands a field back to the constant it stands for.
    function automatic logic [31:0] expand(input logic [1:0] m, input logic [23:0] f);
        logic [31:0] t;
        case (m)
            2'd0, 2'd1: t = {8'd0, f};
            2'd2:       t = {{6{f[23]}}, f, 2'b00};
            default: begin
                t = {24'd0, f[7:0]};
                for (int i = 0; i < 2 * int'(f[11:8]); i++) t = {t[0], t[31:1]};
            end
        endcase
        return t;
    endfunction

    // Every cycle a result is presented it must equal the model's answer for the request.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            check("x_vs_model", {8'd0, x}, {8'd0, exp_x});
            check("ok_vs_model", {31'd0, ok}, {31'd0, exp_ok});
            check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic run_req(input logic [1:0] m, input logic [31:0] v, input logic use_lit,
                           input logic [23:0] lx, input logic lok, input int llat,
                           input int hold);
        logic [23:0] mx;
        logic        mok;
        int          mlat;
        int          lat;
        logic        seen;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        model(m, v, mx, mok, mlat);
        exp_x     = mx;
        exp_ok    = mok;
        in_valid  = 1'b1;
        value     = v;
        ImmSrc    = m;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        value    = $urandom;
        ImmSrc   = 2'($urandom_range(0, 3));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no out_valid after %0d cycles, expected latency %0d",
                     lat, mlat);
        end else begin
            check("latency_vs_model", lat, mlat);
            if (use_lit) begin
                check("x_literal", {8'd0, x}, {8'd0, lx});
                check("ok_literal", {31'd0, ok}, {31'd0, lok});
                check("latency_literal", lat, llat);
            end
            if (ok) check("round_trip", expand(m, x), v);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                value    = $urandom;
                ImmSrc   = 2'($urandom_range(0, 3));
                @(negedge clk);
                check("hold_out_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            check("after_hold_no_out_valid", {31'd0, out_valid}, 32'd0);
            check("after_hold_in_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m;
        logic [31:0] v;
        logic        stray;
        checks    = 0;
        errors    = 0;
        exp_x     = '0;
        exp_ok    = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        value     = '0;
        ImmSrc    = 2'd0;
        out_ready = 1'b0;
        #12;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_x", {8'd0, x}, 32'd0);
        check("reset_ok", {31'd0, ok}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_req(2'd0, 32'h0000_00AB, 1'b1, 24'h0000AB, 1'b1, 1, 0);
        run_req(2'd0, 32'h0000_01FF, 1'b1, 24'h000000, 1'b0, 1, 0);
        run_req(2'd2, 32'hFFFF_FFF8, 1'b1, 24'hFFFFFE, 1'b1, 1, 0);
        run_req(2'd2, 32'h0000_0006, 1'b1, 24'h000000, 1'b0, 1, 0);
        run_req(2'd2, 32'h0200_0000, 1'b1, 24'h000000, 1'b0, 1, 0);
        run_req(2'd3, 32'hFF00_0000, 1'b1, 24'h0004FF, 1'b1, 6, 0);
        run_req(2'd3, 32'h0000_03FC, 1'b1, 24'h000FFF, 1'b1, 17, 0);
        run_req(2'd3, 32'h0000_0000, 1'b1, 24'h000000, 1'b1, 2, 0);
        run_req(2'd3, 32'h0000_0102, 1'b1, 24'h000000, 1'b0, 17, 5);

        // Abort a search at rotation 7 with reset.
        @(negedge clk);
        in_valid = 1'b1;
        value    = 32'h0000_0102;
        ImmSrc   = 2'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midsearch_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midsearch_reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midsearch_reset_x", {8'd0, x}, 32'd0);
        check("midsearch_reset_ok", {31'd0, ok}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        check("no_stray_out_valid", {31'd0, stray}, 32'd0);
        run_req(2'd1, 32'h0000_0ABC, 1'b1, 24'h000ABC, 1'b1, 1, 0);

        // Round-trip over all modes, biased so roughly half the requests are encodable.
        for (int n = 0; n < 48; n++) begin
            m = 2'($urandom_range(0, 3));
            v = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                case (m)
                    2'd0:    v = v & 32'h0000_00FF;
                    2'd1:    v = v & 32'h0000_0FFF;
                    2'd2:    v = expand(2'd2, v[23:0]);
                    default: v = expand(2'd3, {12'd0, v[11:0]});
                endcase
            end
            run_req(m, v, 1'b0, 24'd0, 1'b0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Multi-cycle immediate encoder. It is the inverse of the datapath's immediate extender: given a 32-bit constant and an ImmSrc-style mode, it produces the 24-bit instruction immediate field that the extender expands back to the same constant, or reports the constant as unencodable. It sits beside the instruction assembler/patch path and uses a valid/ready handshake on both sides. Rotated-immediate mode searches one rotation per clock.

## Interface
Parameters:
- none (all widths fixed by the ISA)

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request (high only in IDLE)
- value  input  32  constant to encode
- ImmSrc  input  2  00 imm8, 01 imm12, 10 branch offset, 11 rotated imm8
- out_valid  output  1  result present (high only in DONE)
- out_ready  input  1  consumer takes result
- x  output  24  encoded immediate field; 0 when ok=0
- ok  output  1  1 = encodable, x valid

## Operation
- Request accepted on an edge where in_valid & in_ready; value and ImmSrc are latched; later input changes are ignored.
- Mode 00: ok = (value[31:8]==0); x = {16'b0, value[7:0]}.
- Mode 01: ok = (value[31:12]==0); x = {12'b0, value[11:0]}.
- Mode 10 (byte offset): ok = (value[1:0]==0) & value[31:25] all equal; x = value[25:2].
- Mode 11: for r = 0..15, match iff rol32(value, 2r)[31:8]==0. On first (smallest) match: x = {12'b0, r[3:0], rol32(value,2r)[7:0]}, ok=1. No match after r=15: ok=0.
- State machine:
  - IDLE: in_ready=1. On accept, modes 00–10 → DONE with result registered. Mode 11 → SEARCH with r=0.
  - SEARCH: each edge evaluates the current r.
    - Match → DONE, ok=1.
    - r==15 with no match → DONE, ok=0.
    - Otherwise r+1.
  - DONE: out_valid=1; x/ok held stable. When out_ready is high → IDLE.
- Back-to-back: a new request is never accepted in the same cycle as the DONE→IDLE handoff.
- The rotation counter never wraps. SEARCH exits at r=15 unconditionally.

## Timing
- Reset (async assert, sync release irrelevant to spec): state IDLE, r=0, x=0, ok=0, out_valid=0, in_ready=1.
- Reset asserted mid-SEARCH or in DONE aborts immediately. The pending result is lost; no out_valid pulse follows.
- Latency is counted in cycles from the accepting edge to the first cycle with out_valid=1:
  - modes 00/01/10: 1
  - mode 11, match at rotation k: k+2
  - mode 11, no match: 17
- Output hold: x and ok are stable for the entire period out_valid=1, regardless of value/ImmSrc/in_valid activity.
- Throughput: at most one result per latency+1 cycles (DONE→IDLE costs one cycle).
- in_valid high while in_ready=0 is ignored; no queueing.

## Structure
- Package imm_pkg holds:
  - mode constants IMM8=2'b00, IMM12=2'b01, BRANCH=2'b10, ROT8=2'b11
  - state enum {IDLE, SEARCH, DONE}
  - width constants (32, 24)
- One sub-module, imm_rot_match: a combinational module with inputs value[31:0] and r[3:0], and outputs match and imm8[7:0] (rol-by-2r and upper-zero check). It is instantiated once and reused every SEARCH cycle.
- The top level contains the FSM, the rotation counter, the latched request and the result registers.

## Test plan
- Mode 00: value 0x000000AB → ok=1, x=0x0000AB, latency 1. Value 0x000001FF → ok=0, x=0.
- Mode 10:
  - 0xFFFFFFF8 → ok=1, x=0xFFFFFE, latency 1
  - 0x00000006 → ok=0 (misaligned)
  - 0x02000000 → ok=0 (out of range)
- Mode 11:
  - 0xFF000000 → ok=1, x=0x0004FF, latency 6
  - 0x000003FC → ok=1, x=0x000FFF, latency 17
  - 0x00000000 → x=0, ok=1, latency 2
- Mode 11: 0x00000102 → ok=0, x=0, latency 17. Additionally, hold out_ready=0 for 5 cycles: out_valid, x and ok stay stable, in_ready stays 0, and a new in_valid is ignored.
- Pull reset_n low during SEARCH at r=7 → outputs immediately at reset values. After release, no stray out_valid; a fresh mode 01 request with 0xABC → x=0x000ABC, ok=1, latency 1.
- Round-trip: random values in all modes; whenever ok=1, the extender's expansion of x (plus rotation for mode 11) equals value.
